// File: rtl/irq_arbiter_if.sv
// Handshake and bus-control bundle between the interrupt arbiter and its
// peripherals / CPU / bus master. BUS_DATA stays a plain inout on the arbiter.
interface irq_arbiter_if #(
  parameter int N_SRC = 4
);
  logic [N_SRC-1:0] SRC_IRQ;
  logic [N_SRC-1:0] SRC_ACK;
  logic [N_SRC-1:0] CPU_INT_RAISE;
  logic [N_SRC-1:0] CPU_INT_ACK;
  logic [7:0]       BUS_ADDR;
  logic             BUS_WE;

  modport master (
    output SRC_IRQ, CPU_INT_ACK, BUS_ADDR, BUS_WE,
    input  SRC_ACK, CPU_INT_RAISE
  );

  modport slave (
    input  SRC_IRQ, CPU_INT_ACK, BUS_ADDR, BUS_WE,
    output SRC_ACK, CPU_INT_RAISE
  );
endinterface

// File: rtl/irq_arbiter.sv
// Round-robin interrupt arbiter: latches rising-edge requests, grants one source
// at a time to the CPU, and exposes MASK / PENDING (W1C) on a small data bus.
module irq_arbiter #(
  parameter int          N_SRC       = 4,
  parameter logic [7:0]  BASE_ADDR   = 8'hE0,
  parameter logic [7:0]  MASK_RESET  = 8'hFF,
  parameter int          ACK_TIMEOUT = 1024
) (
  input  logic         CLK,
  input  logic         RESET,
  irq_arbiter_if.slave bus,
  inout  wire  [7:0]   BUS_DATA
);

  localparam int         IW        = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int         CW        = $clog2(ACK_TIMEOUT);
  localparam logic [7:0] PEND_ADDR = BASE_ADDR + 8'd1;
  localparam logic [7:0] MASK_RST8 = MASK_RESET;

  typedef enum logic [1:0] {IDLE, GRANT, WAIT_ACK} state_t;

  state_t           state_reg;
  logic [IW-1:0]    grant_reg;
  logic [IW-1:0]    rr_ptr_reg;
  logic [CW-1:0]    cnt_reg;
  logic [N_SRC-1:0] irq_d_reg;
  logic [N_SRC-1:0] pending_reg;
  logic [N_SRC-1:0] mask_reg;
  logic [N_SRC-1:0] raise_reg;
  logic [N_SRC-1:0] src_ack_reg;

  logic [N_SRC-1:0] pending_next;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] irq_edge;
  logic [N_SRC-1:0] grant_onehot;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] w1c_bits;
  logic [IW-1:0]    sel_idx;
  logic             sel_valid;
  logic             ack_hit;
  logic             wr_mask;
  logic             wr_pend;
  logic             rd_en;
  logic [7:0]       rd_data;

  function automatic logic [IW-1:0] inc_idx(input logic [IW-1:0] g);
    return (int'(g) == N_SRC - 1) ? '0 : g + 1'b1;
  endfunction

  assign eligible = pending_reg & mask_reg;
  assign irq_edge = bus.SRC_IRQ & ~irq_d_reg;
  assign wr_mask  = bus.BUS_WE && (bus.BUS_ADDR == BASE_ADDR);
  assign wr_pend  = bus.BUS_WE && (bus.BUS_ADDR == PEND_ADDR);
  assign ack_hit  = (state_reg == WAIT_ACK) && bus.CPU_INT_ACK[grant_reg];
  assign w1c_bits = wr_pend ? BUS_DATA[N_SRC-1:0] : '0;
  assign ack_clr  = ack_hit ? grant_onehot : '0;

  // A new edge always wins over an ACK clear or a software clear in the same cycle.
  assign pending_next = (pending_reg & ~ack_clr & ~w1c_bits) | irq_edge;

  always_comb begin
    grant_onehot = '0;
    grant_onehot[grant_reg] = 1'b1;
  end

  // Scan downward so the candidate closest to rr_ptr (smallest offset) wins.
  always_comb begin
    int p;
    p         = 0;
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      p = int'(rr_ptr_reg) + k;
      if (p >= N_SRC) p = p - N_SRC;
      if (eligible[IW'(p)]) begin
        sel_valid = 1'b1;
        sel_idx   = IW'(p);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      irq_d_reg   <= '0;
      pending_reg <= '0;
      mask_reg    <= MASK_RST8[N_SRC-1:0];
    end else begin
      irq_d_reg   <= bus.SRC_IRQ;
      pending_reg <= pending_next;
      if (wr_mask) mask_reg <= BUS_DATA[N_SRC-1:0];
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg   <= IDLE;
      grant_reg   <= '0;
      rr_ptr_reg  <= '0;
      cnt_reg     <= '0;
      raise_reg   <= '0;
      src_ack_reg <= '0;
    end else begin
      src_ack_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (sel_valid) begin
            grant_reg <= sel_idx;
            state_reg <= GRANT;
          end
        end
        GRANT: begin
          raise_reg <= grant_onehot;
          cnt_reg   <= CW'(ACK_TIMEOUT - 1);
          state_reg <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (ack_hit) begin
            raise_reg   <= '0;
            src_ack_reg <= grant_onehot;
            rr_ptr_reg  <= inc_idx(grant_reg);
            state_reg   <= IDLE;
          end else if (cnt_reg == '0) begin
            // Abandon the grant; the request stays pending for a later retry.
            raise_reg  <= '0;
            rr_ptr_reg <= inc_idx(grant_reg);
            state_reg  <= IDLE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: begin
          raise_reg <= '0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.CPU_INT_RAISE = raise_reg;
  assign bus.SRC_ACK       = src_ack_reg;

  assign rd_en   = !bus.BUS_WE && ((bus.BUS_ADDR == BASE_ADDR) || (bus.BUS_ADDR == PEND_ADDR));
  assign rd_data = (bus.BUS_ADDR == BASE_ADDR) ? 8'(mask_reg) : 8'(pending_reg);
  assign BUS_DATA = rd_en ? rd_data : 8'bz;

  generate
    if (N_SRC < 8) begin : g_unused_bits
      logic unused_bus_bits;
      assign unused_bus_bits = &{1'b0, BUS_DATA[7:N_SRC]};
    end
  endgenerate

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: latency, round-robin order, masking,
// timeout, set/clear collisions, W1C and asynchronous reset.
module tb_irq_arbiter;

  localparam logic [7:0] MASK_A = 8'hE0;
  localparam logic [7:0] PEND_A = 8'hE1;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       bus_oe = 1'b0;
  logic [7:0] bus_drv = 8'h00;
  wire  [7:0] BUS_DATA;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  assign BUS_DATA = bus_oe ? bus_drv : 8'bz;

  irq_arbiter_if #(.N_SRC(4)) bus ();

  irq_arbiter #(
    .N_SRC      (4),
    .BASE_ADDR  (8'hE0),
    .MASK_RESET (8'hFF),
    .ACK_TIMEOUT(8)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .bus     (bus),
    .BUS_DATA(BUS_DATA)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    bus.BUS_ADDR = a;
    bus.BUS_WE   = 1'b0;
    bus_oe       = 1'b0;
    #1;
    d = BUS_DATA;
    bus.BUS_ADDR = 8'h00;
    $display("  bus read  addr=%h data=%h", a, d);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    bus.BUS_ADDR = a;
    bus_drv      = d;
    bus_oe       = 1'b1;
    bus.BUS_WE   = 1'b1;
    tick();
    bus.BUS_WE   = 1'b0;
    bus_oe       = 1'b0;
    bus.BUS_ADDR = 8'h00;
    $display("  bus write addr=%h data=%h", a, d);
  endtask

  task automatic wait_raise(input int budget);
    int w = 0;
    while (bus.CPU_INT_RAISE == 4'b0000 && w < budget) begin
      tick();
      w++;
    end
  endtask

  task automatic do_reset();
    bus.SRC_IRQ     = '0;
    bus.CPU_INT_ACK = '0;
    bus.BUS_WE      = 1'b0;
    bus.BUS_ADDR    = 8'h00;
    bus_oe          = 1'b0;
    RESET           = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [7:0] d;
    do_reset();
    n_checks++;
    if (bus.CPU_INT_RAISE !== 4'b0000) begin n_fail++; $display("FAIL reset_raise: got %b expected 0000", bus.CPU_INT_RAISE); end
    n_checks++;
    if (bus.SRC_ACK !== 4'b0000) begin n_fail++; $display("FAIL reset_src_ack: got %b expected 0000", bus.SRC_ACK); end
    bus_read(MASK_A, d);
    n_checks++;
    if (d !== 8'h0F) begin n_fail++; $display("FAIL reset_mask: got %h expected 0f", d); end
    bus_read(PEND_A, d);
    n_checks++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL reset_pending: got %h expected 00", d); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [7:0] d;
    bus.SRC_IRQ = 4'b0010;
    tick();
    bus_read(PEND_A, d);
    n_checks++;
    if (d !== 8'h02) begin n_fail++; $display("FAIL single_pend_set: got %h expected 02", d); end
    tick();
    n_checks++;
    if (bus.CPU_INT_RAISE !== 4'b0000) begin n_fail++; $display("FAIL single_raise_early: got %b expected 0000", bus.CPU_INT_RAISE); end
    tick();
    n_checks++;
    if (bus.CPU_INT_RAISE !== 4'b0010) begin n_fail++; $display("FAIL single_latency: got %b expected 0010", bus.CPU_INT_RAISE); end
    repeat (5) tick();
    n_checks++;
    if (bus.CPU_INT_RAISE !== 4'b0010) begin n_fail++; $display("FAIL single_hold: got %b expected 0010", bus.CPU_INT_RAISE); end
    bus.CPU_INT_ACK = 4'b0010;
    tick();
    bus.CPU_INT_ACK = 4'b0000;
    n_checks++;
    if (bus.CPU_INT_RAISE !== 4'b0000) begin n_fail++; $display("FAIL single_drop: got %b expected 0000", bus.CPU_INT_RAISE); end
    n_checks++;
    if (bus.SRC_ACK !== 4'b0010) begin n_fail++; $display("FAIL single_src_ack: got %b expected 0010", bus.SRC_ACK); end
    tick();
    n_checks++;
    if (bus.SRC_ACK !== 4'b0000) begin n_fail++; $display("FAIL single_ack_pulse: got %b expected 0000", bus.SRC_ACK); end
    // SRC_IRQ[1] is still high here: a held level must not re-arm the request.
    bus_read(PEND_A, d);
    n_checks++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL single_pend_clr: got %h expected 00", d); end
    bus.SRC_IRQ = 4'b0000;
    tick();
    $display("test_single done");
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_a [3];
    logic [3:0] exp_b [2];
    logic [7:0] d;
    exp_a[0] = 4'b0001; exp_a[1] = 4'b0100; exp_a[2] = 4'b1000;
    exp_b[0] = 4'b0001; exp_b[1] = 4'b1000;
    do_reset();
    bus.SRC_IRQ = 4'b1101;
    tick();
    bus.SRC_IRQ = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      wait_raise(20);
      n_checks++;
      if (bus.CPU_INT_RAISE !== exp_a[i]) begin n_fail++; $display("FAIL rr_grant_a%0d: got %b expected %b", i, bus.CPU_INT_RAISE, exp_a[i]); end
      tick();
      tick();
      bus.CPU_INT_ACK = bus.CPU_INT_RAISE;
      tick();
      bus.CPU_INT_ACK = 4'b0000;
      n_checks++;
      if (bus.SRC_ACK !== exp_a[i]) begin n_fail++; $display("FAIL rr_src_ack_a%0d: got %b expected %b", i, bus.SRC_ACK, exp_a[i]); end
    end
    bus.SRC_IRQ = 4'b1001;
    tick();
    bus.SRC_IRQ = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      wait_raise(20);
      n_checks++;
      if (bus.CPU_INT_RAISE !== exp_b[i]) begin n_fail++; $display("FAIL rr_grant_b%0d: got %b expected %b", i, bus.CPU_INT_RAISE, exp_b[i]); end
      tick();
      tick();
      bus.CPU_INT_ACK = bus.CPU_INT_RAISE;
      tick();
      bus.CPU_INT_ACK = 4'b0000;
    end
    bus_read(PEND_A, d);
    n_checks++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL rr_pend_empty: got %h expected 00", d); end
    $display("test_round_robin done");
  endtask

  task automatic test_mask();
    logic [7:0] d;
    do_reset();
    bus_write(MASK_A, 8'h0E);
    bus.SRC_IRQ = 4'b0001;
    tick();
    bus.SRC_IRQ = 4'b0000;
    repeat (5) tick();
    n_checks++;
    if (bus.CPU_INT_RAISE !== 4'b0000) begin n_fail++; $display("FAIL mask_blocked: got %b expected 0000", bus.CPU_INT_RAISE); end
    bus_read(PEND_A, d);
    n_checks++;
    if (d !== 8'h01) begin n_fail++; $display("FAIL mask_pend: got %h expected 01", d); end
    bus_read(MASK_A, d);
    n_checks++;
    if (d !== 8'h0E) begin n_fail++; $display("FAIL mask_readback: got %h expected 0e", d); end
    bus_write(MASK_A, 8'h0F);
    wait_raise(3);
    n_checks++;
    if (bus.CPU_INT_RAISE !== 4'b0001) begin n_fail++; $display("FAIL mask_release: got %b expected 0001", bus.CPU_INT_RAISE); end
    bus.CPU_INT_ACK = 4'b0001;
    tick();
    bus.CPU_INT_ACK = 4'b0000;
    bus_read(PEND_A, d);
    n_checks++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL mask_pend_clr: got %h expected 00", d); end
    $display("test_mask done");
  endtask

  task automatic test_timeout();
    logic [7:0] d;
    int hi;
    do_reset();
    bus.SRC_IRQ = 4'b0100;
    tick();
    bus.SRC_IRQ = 4'b0000;
    wait_raise(10);
    hi = 0;
    while (bus.CPU_INT_RAISE == 4'b0100 && hi < 40) begin
      hi++;
      tick();
    end
    n_checks++;
    if (hi != 8) begin n_fail++; $display("FAIL timeout_high_cycles: got %0d expected 8", hi); end
    n_checks++;
    if (bus.SRC_ACK !== 4'b0000) begin n_fail++; $display("FAIL timeout_no_ack: got %b expected 0000", bus.SRC_ACK); end
    bus_read(PEND_A, d);
    n_checks++;
    if (d !== 8'h04) begin n_fail++; $display("FAIL timeout_pend_kept: got %h expected 04", d); end
    tick();
    n_checks++;
    if (bus.CPU_INT_RAISE !== 4'b0000) begin n_fail++; $display("FAIL timeout_idle_gap: got %b expected 0000", bus.CPU_INT_RAISE); end
    tick();
    n_checks++;
    if (bus.CPU_INT_RAISE !== 4'b0100) begin n_fail++; $display("FAIL timeout_regrant: got %b expected 0100", bus.CPU_INT_RAISE); end
    bus.CPU_INT_ACK = 4'b0100;
    tick();
    bus.CPU_INT_ACK = 4'b0000;
    n_checks++;
    if (bus.SRC_ACK !== 4'b0100) begin n_fail++; $display("FAIL timeout_late_ack: got %b expected 0100", bus.SRC_ACK); end
    $display("test_timeout done");
  endtask

  task automatic test_simultaneous();
    logic [7:0] d;
    do_reset();
    bus.SRC_IRQ = 4'b0010;
    tick();
    bus.SRC_IRQ = 4'b0000;
    wait_raise(10);
    n_checks++;
    if (bus.CPU_INT_RAISE !== 4'b0010) begin n_fail++; $display("FAIL simul_first_grant: got %b expected 0010", bus.CPU_INT_RAISE); end
    tick();
    bus.SRC_IRQ     = 4'b0010;
    bus.CPU_INT_ACK = 4'b0010;
    tick();
    bus.CPU_INT_ACK = 4'b0000;
    bus.SRC_IRQ     = 4'b0000;
    n_checks++;
    if (bus.SRC_ACK !== 4'b0010) begin n_fail++; $display("FAIL simul_src_ack: got %b expected 0010", bus.SRC_ACK); end
    bus_read(PEND_A, d);
    n_checks++;
    if (d !== 8'h02) begin n_fail++; $display("FAIL simul_set_wins: got %h expected 02", d); end
    wait_raise(10);
    n_checks++;
    if (bus.CPU_INT_RAISE !== 4'b0010) begin n_fail++; $display("FAIL simul_regrant: got %b expected 0010", bus.CPU_INT_RAISE); end
    bus.CPU_INT_ACK = 4'b0010;
    tick();
    bus.CPU_INT_ACK = 4'b0000;
    bus_write(MASK_A, 8'h0D);
    bus.SRC_IRQ = 4'b0010;
    tick();
    bus.SRC_IRQ = 4'b0000;
    bus_read(PEND_A, d);
    n_checks++;
    if (d !== 8'h02) begin n_fail++; $display("FAIL w1c_pend_before: got %h expected 02", d); end
    bus_write(PEND_A, 8'h02);
    bus_read(PEND_A, d);
    n_checks++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL w1c_clear: got %h expected 00", d); end
    bus_write(MASK_A, 8'h0F);
    $display("test_simultaneous done");
  endtask

  task automatic test_async_reset();
    logic [7:0] d;
    do_reset();
    bus.SRC_IRQ = 4'b0101;
    tick();
    bus.SRC_IRQ = 4'b0000;
    wait_raise(10);
    n_checks++;
    if (bus.CPU_INT_RAISE !== 4'b0001) begin n_fail++; $display("FAIL areset_grant: got %b expected 0001", bus.CPU_INT_RAISE); end
    bus_read(PEND_A, d);
    n_checks++;
    if (d !== 8'h05) begin n_fail++; $display("FAIL areset_pend_before: got %h expected 05", d); end
    // Assert reset mid-cycle, well away from any rising clock edge.
    #2;
    RESET = 1'b0;
    #1;
    n_checks++;
    if (bus.CPU_INT_RAISE !== 4'b0000) begin n_fail++; $display("FAIL areset_raise: got %b expected 0000", bus.CPU_INT_RAISE); end
    bus_read(PEND_A, d);
    n_checks++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL areset_pend: got %h expected 00", d); end
    tick();
    RESET = 1'b1;
    tick();
    bus_read(MASK_A, d);
    n_checks++;
    if (d !== 8'h0F) begin n_fail++; $display("FAIL areset_mask: got %h expected 0f", d); end
    n_checks++;
    if (bus.CPU_INT_RAISE !== 4'b0000) begin n_fail++; $display("FAIL areset_raise_after: got %b expected 0000", bus.CPU_INT_RAISE); end
    $display("test_async_reset done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.SRC_IRQ     = '0;
    bus.CPU_INT_ACK = '0;
    bus.BUS_ADDR    = 8'h00;
    bus.BUS_WE      = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_mask();
    test_timeout();
    test_simultaneous();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
